// File: rtl/vote_pkg.sv
// Shared types and constants for the vote input front-end.
// Holds the candidate count, the default debounce length and the lockout FSM states.
package vote_pkg;

    localparam int NUM_CAND         = 4;
    localparam int DEFAULT_DEBOUNCE = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
        return (v != '0) && ((v & (v - {{(NUM_CAND-1){1'b0}}, 1'b1})) == '0);
    endfunction

endpackage

// File: rtl/vote_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter and debounced level.
// Latency: deb follows a clean raw edge DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running level filter.
module vote_debounce
    import vote_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             s;
    logic [CNT_W-1:0] cnt;

    // The counter runs while s disagrees with deb; deb only moves once the
    // counter has already climbed to DEBOUNCE_CYCLES and s is still different.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            if (s == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vote_input_conditioner.sv
// Turns four bouncy candidate buttons into one single-cycle vote pulse per press.
// Latency: valid_i rises DEBOUNCE_CYCLES+3 edges after a clean press is first sampled.
// Backpressure: none; after any press, further presses are locked out until all buttons release.
module vote_input_conditioner
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cand1,
    input  logic                cand2,
    input  logic                cand3,
    input  logic                cand4,
    input  logic                mode,
    output logic                valid1,
    output logic                valid2,
    output logic                valid3,
    output logic                valid4,
    output logic                reject,
    output logic                busy,
    output logic [NUM_CAND-1:0] deb
);

    logic [NUM_CAND-1:0] raw;
    assign raw = {cand4, cand3, cand2, cand1};

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_ch
        vote_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (raw[i]),
            .deb  (deb[i])
        );
    end

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CAND-1:0] vld_q;
    logic [NUM_CAND-1:0] vld_nxt;
    logic                rej_q;
    logic                rej_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            vld_q <= '0;
            rej_q <= 1'b0;
        end else begin
            state <= state_nxt;
            vld_q <= vld_nxt;
            rej_q <= rej_nxt;
        end
    end

    // Any non-zero debounced pattern seen from IDLE locks; only a full release unlocks.
    always_comb begin
        state_nxt = state;
        vld_nxt   = '0;
        rej_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (deb != '0) begin
                    state_nxt = LOCK;
                    if (!mode) begin
                        if (is_onehot(deb)) vld_nxt = deb;
                        else                rej_nxt = 1'b1;
                    end
                end
            end
            LOCK: begin
                if (deb == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign valid1 = vld_q[0];
    assign valid2 = vld_q[1];
    assign valid3 = vld_q[2];
    assign valid4 = vld_q[3];
    assign reject = rej_q;
    assign busy   = (state == LOCK);

endmodule

// File: tb/tb_vote_input_conditioner.sv
// Bench for vote_input_conditioner: directed scenarios plus random bouncing,
// all checked every cycle against a window-based behavioural model.
module tb_vote_input_conditioner;

    localparam int D   = 8;
    localparam int LAT = D + 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       cand1, cand2, cand3, cand4;
    logic       mode;
    logic       valid1, valid2, valid3, valid4;
    logic       reject;
    logic       busy;
    logic [3:0] deb;

    vote_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .cand1 (cand1),
        .cand2 (cand2),
        .cand3 (cand3),
        .cand4 (cand4),
        .mode  (mode),
        .valid1(valid1),
        .valid2(valid2),
        .valid3(valid3),
        .valid4(valid4),
        .reject(reject),
        .busy  (busy),
        .deb   (deb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit started = 1'b0;

    // Model: sync is a two-sample delay; a debounced level flips once the
    // last D+1 synchronised samples all disagree with it.
    bit [3:0] m_raw1, m_raw2, m_deb, m_valid;
    bit [D:0] m_hist [4];
    bit       m_lock, m_reject;

    always @(posedge clk) begin : model
        cyc++;
        if (reset) begin
            m_raw1 = '0; m_raw2 = '0; m_deb = '0;
            m_valid = '0; m_reject = 0; m_lock = 0;
            for (int i = 0; i < 4; i++) m_hist[i] = '0;
        end else begin
            m_valid  = '0;
            m_reject = 0;
            if (!m_lock) begin
                if (m_deb != 0) begin
                    m_lock = 1;
                    if (!mode) begin
                        if ($countones(m_deb) == 1) m_valid = m_deb;
                        else                        m_reject = 1;
                    end
                end
            end else if (m_deb == 0) begin
                m_lock = 0;
            end
            for (int i = 0; i < 4; i++) begin
                m_hist[i] = {m_hist[i][D-1:0], m_raw2[i]};
                if (m_hist[i] == {(D+1){~m_deb[i]}}) m_deb[i] = ~m_deb[i];
            end
            m_raw2 = m_raw1;
            m_raw1 = {cand4, cand3, cand2, cand1};
        end
    end

    int  cnt_valid [4];
    int  cnt_reject, busy_rises, deb2_seen, pulse_cyc, busy_fall_cyc;
    bit  busy_prev = 0;

    always @(negedge clk) begin : compare
        if (started) begin
            checks++;
            if ({valid4, valid3, valid2, valid1, reject, busy, deb} !==
                {m_valid, m_reject, m_lock, m_deb}) begin
                errors++;
                $display("FAIL cycle %0d outputs {v4..v1,rej,busy,deb}: dut=%b model=%b",
                         cyc, {valid4, valid3, valid2, valid1, reject, busy, deb},
                         {m_valid, m_reject, m_lock, m_deb});
            end
            if (valid1) begin cnt_valid[0]++; pulse_cyc = cyc; end
            if (valid2) begin cnt_valid[1]++; pulse_cyc = cyc; end
            if (valid3) begin cnt_valid[2]++; pulse_cyc = cyc; end
            if (valid4) begin cnt_valid[3]++; pulse_cyc = cyc; end
            if (reject) cnt_reject++;
            if (deb[2] === 1'b1) deb2_seen++;
            if (busy === 1'b1 && !busy_prev) busy_rises++;
            if (busy === 1'b0 && busy_prev) busy_fall_cyc = cyc;
            busy_prev = (busy === 1'b1);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) cnt_valid[i] = 0;
        cnt_reject = 0; busy_rises = 0; deb2_seen = 0;
        pulse_cyc = -1000; busy_fall_cyc = -1000;
    endtask

    function automatic int all_pulses();
        return cnt_valid[0] + cnt_valid[1] + cnt_valid[2] + cnt_valid[3] + cnt_reject;
    endfunction

    int t0;
    int budget;

    initial begin
        reset = 1; mode = 0;
        cand1 = 0; cand2 = 0; cand3 = 0; cand4 = 0;
        clear_counts();
        run(1);
        started = 1;
        run(1);
        check("reset_outputs", int'({valid4, valid3, valid2, valid1, reject, busy, deb}), 0);
        reset = 0;
        run(2);

        // Clean press on cand1
        clear_counts();
        cand1 = 1; t0 = cyc;
        run(20);
        check("clean_valid1_count", cnt_valid[0], 1);
        check("clean_latency", pulse_cyc - (t0 + 1), LAT);
        check("clean_other_pulses", all_pulses() - cnt_valid[0], 0);
        check("clean_busy_held", int'(busy), 1);
        cand1 = 0; t0 = cyc;
        run(20);
        check("clean_busy_release_latency", busy_fall_cyc - (t0 + 1), LAT);
        check("clean_busy_low", int'(busy), 0);

        // Bounce on cand3, then a solid press
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            cand3 = (i % 2 == 0);
            run(3);
        end
        check("bounce_deb2_never_high", deb2_seen, 0);
        check("bounce_no_pulse", all_pulses(), 0);
        cand3 = 1; t0 = cyc;
        run(20);
        check("bounce_valid3_count", cnt_valid[2], 1);
        check("bounce_latency", pulse_cyc - (t0 + 1), LAT);
        cand3 = 0;
        run(20);

        // Simultaneous cand2 + cand4
        clear_counts();
        cand2 = 1; cand4 = 1;
        run(20);
        check("simul_reject_count", cnt_reject, 1);
        check("simul_no_valid", all_pulses() - cnt_reject, 0);
        check("simul_busy", int'(busy), 1);
        check("simul_deb", int'(deb), 4'b1010);
        check("simul_model_deb", int'(m_deb), 4'b1010);
        cand2 = 0; cand4 = 0;
        run(20);

        // Lockout: second button during LOCK is ignored
        clear_counts();
        cand1 = 1; run(15);
        cand2 = 1; run(15);
        cand1 = 0; run(20);
        check("lock_valid1_once", cnt_valid[0], 1);
        check("lock_no_valid2", cnt_valid[1], 0);
        check("lock_busy_while_cand2", int'(busy), 1);
        cand2 = 0; run(20);
        check("lock_released", int'(busy), 0);
        cand2 = 1; run(20);
        check("lock_fresh_valid2", cnt_valid[1], 1);
        check("lock_total_pulses", all_pulses(), 2);
        cand2 = 0; run(20);

        // Tally mode: selections lock but never vote
        clear_counts();
        mode = 1;
        for (int i = 0; i < 4; i++) begin
            {cand4, cand3, cand2, cand1} = 4'(1 << i);
            run(20);
            {cand4, cand3, cand2, cand1} = 4'b0;
            run(20);
        end
        check("tally_no_pulses", all_pulses(), 0);
        check("tally_busy_rises", busy_rises, 4);
        mode = 0;
        run(2);

        // Reset while cand4 is held produces a fresh vote
        clear_counts();
        cand4 = 1;
        budget = 40;
        while (cnt_valid[3] == 0 && budget > 0) begin run(1); budget--; end
        check("midreset_first_valid4_seen", int'(cnt_valid[3] != 0), 1);
        run(5);
        reset = 1; run(1);
        reset = 0;
        check("midreset_outputs_clear", int'({valid4, valid3, valid2, valid1, reject, busy, deb}), 0);
        clear_counts();
        t0 = cyc;
        run(20);
        check("midreset_second_valid4", cnt_valid[3], 1);
        check("midreset_latency", pulse_cyc - (t0 + 1), LAT);
        cand4 = 0;
        run(20);

        // Random bouncing, mode flips and occasional resets against the model
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            len = $urandom_range(1, 25);
            {cand4, cand3, cand2, cand1} = ($urandom_range(0, 2) == 0) ?
                4'($urandom) : 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) {cand4, cand3, cand2, cand1} = 4'b0;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 30) == 0) reset = 1;
            for (int k = 0; k < len; k++) begin
                run(1);
                reset = 0;
                if ($urandom_range(0, 9) == 0)
                    {cand4, cand3, cand2, cand1} = {cand4, cand3, cand2, cand1} ^ 4'(1 << $urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
